// File: rtl/mul_ctrl_pkg.sv
// Shared constants and types for the multiplier command sequencer.
package mul_ctrl_pkg;

  localparam int unsigned OPND_W = 16;
  localparam int unsigned PROD_W = 32;

  localparam logic [3:0] OP_MUL_U = 4'h2;
  localparam logic [3:0] OP_MUL_S = 4'h3;
  localparam logic [3:0] DT_MUL   = 4'h2;

  localparam int unsigned TIMEOUT_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op == OP_MUL_U) || (op == OP_MUL_S);
  endfunction

endpackage

// File: rtl/mul_sign_adj.sv
// Sign-magnitude helpers: operand magnitudes, result sign, and conditional
// two's-complement negation of the unsigned engine product.
module mul_sign_adj
  import mul_ctrl_pkg::*;
(
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  input  logic              neg_in,
  input  logic [PROD_W-1:0] product,
  output logic [OPND_W-1:0] abs_a,
  output logic [OPND_W-1:0] abs_b,
  output logic              neg,
  output logic [PROD_W-1:0] product_adj
);

  // 0x8000 maps onto itself, which is the correct unsigned magnitude of -32768.
  always_comb begin
    abs_a       = a;
    abs_b       = b;
    neg         = a[OPND_W-1] ^ b[OPND_W-1];
    product_adj = product;
    if (a[OPND_W-1]) begin
      abs_a = ~a + 16'h0001;
    end else begin
      abs_a = a;
    end
    if (b[OPND_W-1]) begin
      abs_b = ~b + 16'h0001;
    end else begin
      abs_b = b;
    end
    if (neg_in && (product != 32'h0000_0000)) begin
      product_adj = ~product + 32'h0000_0001;
    end else begin
      product_adj = product;
    end
  end

endmodule

// File: rtl/mul_ctrl.sv
// Command sequencer for the 16-bit shift-add multiplier engine.
// Define MUL_CTRL_TIMEOUT_EN to build the WAIT-state engine timeout.
module mul_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic [15:0] mul_M,
  output logic [15:0] mul_Q,
  output logic        mul_start,
  output logic [3:0]  mul_dtype,
  input  logic        mul_done,
  input  logic [31:0] mul_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  state_t      state_q, state_d;
  logic [15:0] mul_m_q, mul_m_d;
  logic [15:0] mul_q_q, mul_q_d;
  logic        mul_start_q, mul_start_d;
  logic [3:0]  mul_dtype_q, mul_dtype_d;
  logic        neg_q, neg_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;

  logic [15:0] abs_a_s, abs_b_s;
  logic        neg_s;
  logic [31:0] prod_adj_s;
  logic        is_signed_s;

`ifdef MUL_CTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic [31:0] unused_timeout_s;
  assign unused_timeout_s = 32'(TIMEOUT);
`endif

  assign is_signed_s = (cmd_op == OP_MUL_S);

  mul_sign_adj u_sign_adj (
    .a           (cmd_a),
    .b           (cmd_b),
    .neg_in      (neg_q),
    .product     (mul_result),
    .abs_a       (abs_a_s),
    .abs_b       (abs_b_s),
    .neg         (neg_s),
    .product_adj (prod_adj_s)
  );

  always_comb begin
    state_d     = state_q;
    mul_m_d     = mul_m_q;
    mul_q_d     = mul_q_q;
    mul_start_d = 1'b0;
    mul_dtype_d = 4'h0;
    neg_d       = neg_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
`ifdef MUL_CTRL_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (op_is_legal(cmd_op)) begin
            state_d     = ISSUE;
            mul_m_d     = is_signed_s ? abs_a_s : cmd_a;
            mul_q_d     = is_signed_s ? abs_b_s : cmd_b;
            neg_d       = is_signed_s & neg_s;
            mul_start_d = 1'b1;
            mul_dtype_d = DT_MUL;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = 32'h0000_0000;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef MUL_CTRL_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (mul_done) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = prod_adj_s;
        end
`ifdef MUL_CTRL_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = 32'h0000_0000;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        else begin
          state_d = WAIT;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_data_d  = 32'h0000_0000;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Handshake flags follow the next state so they are registered yet aligned with it.
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      mul_m_q     <= 16'h0000;
      mul_q_q     <= 16'h0000;
      mul_start_q <= 1'b0;
      mul_dtype_q <= 4'h0;
      neg_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mul_m_q     <= mul_m_d;
      mul_q_q     <= mul_q_d;
      mul_start_q <= mul_start_d;
      mul_dtype_q <= mul_dtype_d;
      neg_q       <= neg_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

`ifdef MUL_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign cmd_ready = cmd_ready_q;
  assign mul_M     = mul_m_q;
  assign mul_Q     = mul_q_q;
  assign mul_start = mul_start_q;
  assign mul_dtype = mul_dtype_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// Scoreboard bench for mul_ctrl with a behavioural 18-cycle multiplier engine.
`timescale 1ns/1ps
module tb_mul_ctrl;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_a, cmd_b;
  logic [15:0] mul_M, mul_Q;
  logic        mul_start;
  logic [3:0]  mul_dtype;
  logic        mul_done;
  logic [31:0] mul_result;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err, busy;

  always #5 clk = ~clk;

  mul_ctrl dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .mul_M(mul_M), .mul_Q(mul_Q), .mul_start(mul_start), .mul_dtype(mul_dtype),
    .mul_done(mul_done), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural engine ----------------
  logic        eng_hang = 1'b0;
  logic        spur_req = 1'b0;
  int          eng_cnt = 0;
  logic [15:0] eng_m, eng_q;
  int          n_starts = 0;
  int          last_acc = -100;
  logic [15:0] exp_m, exp_q_op;

  initial begin
    mul_done = 1'b0;
    mul_result = 32'h0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        eng_cnt = 0; mul_done = 1'b0; mul_result = 32'h0;
      end else begin
        mul_done = 1'b0;
        mul_result = 32'h0;
        check("dtype", 32'(mul_dtype), mul_start ? 32'h2 : 32'h0);
        if (spur_req) begin
          mul_done = 1'b1; mul_result = 32'hDEADBEEF; spur_req = 1'b0;
        end
        if (eng_cnt > 0) begin
          check("m_stable", 32'(mul_M), 32'(eng_m));
          check("q_stable", 32'(mul_Q), 32'(eng_q));
          eng_cnt--;
          if (eng_cnt == 0) begin
            mul_done = 1'b1;
            mul_result = {16'h0, eng_m} * {16'h0, eng_q};
          end
        end
        if (mul_start) begin
          n_starts++;
          check("start_cycle", cyc, last_acc + 1);
          check("mul_M", 32'(mul_M), 32'(exp_m));
          check("mul_Q", 32'(mul_Q), 32'(exp_q_op));
          eng_m = mul_M; eng_q = mul_Q;
          eng_cnt = eng_hang ? 0 : 18;
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  bit   presenting = 1'b0;
  exp_t cur;
  logic [31:0] held_data;
  int   hs_cyc = -1;

  initial begin
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        presenting = 1'b0;
      end else if (rsp_valid) begin
        if (!presenting) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 32'(rsp_valid), 32'h0);
          end else begin
            cur = exp_q.pop_front();
            check("rsp_data", rsp_data, cur.data);
            check("rsp_err", 32'(rsp_err), 32'(cur.err));
            check("rsp_latency", cyc - cur.acc, cur.lat);
          end
          held_data = rsp_data;
          presenting = 1'b1;
        end else begin
          check("rsp_stable", rsp_data, held_data);
        end
        check("cmd_ready_in_resp", 32'(cmd_ready), 32'h0);
        if (rsp_ready) begin
          presenting = 1'b0;
          hs_cyc = cyc;
        end
      end
    end
  end

  // ---------------- ready driver ----------------
  bit rdy_rand = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #2;
      if (rdy_rand) rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- command driver + reference model ----------------
  int  legal_acc = 0;
  int  acc_cyc = -1;
  bit  tmo_mode = 1'b0;
`ifdef MUL_CTRL_TIMEOUT_EN
  localparam int TO = 32;
`endif

  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input bit push);
    exp_t  e;
    int    sa, sb, ma, mb;
    longint p;
    bit    legal, sgn, accepted;
    accepted = 1'b0;
    @(posedge clk); #2;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        legal = (op == 4'h2) || (op == 4'h3);
        sgn   = (op == 4'h3);
        sa = (sgn && a >= 16'h8000) ? int'(a) - 65536 : int'(a);
        sb = (sgn && b >= 16'h8000) ? int'(b) - 65536 : int'(b);
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        p  = longint'(sa) * longint'(sb);
        e.data = legal ? p[31:0] : 32'h0;
        e.err  = !legal;
        e.acc  = cyc;
        e.lat  = legal ? 20 : 1;
`ifdef MUL_CTRL_TIMEOUT_EN
        if (tmo_mode && legal) begin
          e.data = 32'h0; e.err = 1'b1; e.lat = TO + 3;
        end
`endif
        exp_m    = ma[15:0];
        exp_q_op = mb[15:0];
        last_acc = cyc;
        acc_cyc  = cyc;
        if (legal) legal_acc++;
        if (push) exp_q.push_back(e);
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) check("cmd_accept_timeout", 32'h0, 32'h1);
    @(posedge clk); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 32'h0, 32'h1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},      32'(busy),      32'h0);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, "_rsp_data"},  rsp_data,       32'h0);
    check({tag, "_rsp_err"},   32'(rsp_err),   32'h0);
    check({tag, "_mul_M"},     32'(mul_M),     32'h0);
    check({tag, "_mul_Q"},     32'(mul_Q),     32'h0);
    check({tag, "_mul_start"}, 32'(mul_start), 32'h0);
    check({tag, "_mul_dtype"}, 32'(mul_dtype), 32'h0);
  endtask

  function automatic logic [15:0] pick_opnd();
    int r;
    r = int'($urandom_range(0, 5));
    case (r)
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  bit done2 = 1'b0;

  initial begin
    logic [3:0] op;
    bit         seen;
    cmd_valid = 1'b0; cmd_op = 4'h0; cmd_a = 16'h0; cmd_b = 16'h0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    #2 n_rst = 1'b1;

    // directed cases
    send(4'h2, 16'hFFFF, 16'hFFFF, 1'b1); wait_idle(100);
    send(4'h3, 16'hFFFF, 16'h0003, 1'b1); wait_idle(100);
    send(4'h3, 16'h8000, 16'h8000, 1'b1); wait_idle(100);
    send(4'h3, 16'h8000, 16'h0000, 1'b1); wait_idle(100);
    send(4'h7, 16'h1234, 16'h5678, 1'b1); wait_idle(100);

    // stray completion pulse while idle must be ignored
    spur_req = 1'b1;
    repeat (3) @(negedge clk);
    check("spur_busy", 32'(busy), 32'h0);
    check("spur_rsp_valid", 32'(rsp_valid), 32'h0);
    check("spur_cmd_ready", 32'(cmd_ready), 32'h1);

    // back-pressure with a second command queued behind it
    @(posedge clk); #2 rsp_ready = 1'b0;
    send(4'h2, 16'h1234, 16'h0056, 1'b1);
    fork
      begin send(4'h3, 16'hFF00, 16'h00CD, 1'b1); done2 = 1'b1; end
    join_none
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1'b1; break; end
    end
    check("bp_rsp_seen", 32'(seen), 32'h1);
    repeat (5) begin
      @(negedge clk);
      check("bp_cmd_ready", 32'(cmd_ready), 32'h0);
      check("bp_rsp_held", 32'(rsp_valid), 32'h1);
    end
    @(posedge clk); #2 rsp_ready = 1'b1;
    for (int i = 0; i < 50 && !done2; i++) @(negedge clk);
    check("bp_second_done", 32'(done2), 32'h1);
    check("bp_accept_cycle", acc_cyc, hs_cyc + 1);
    wait_idle(100);

    // hung engine
`ifdef MUL_CTRL_TIMEOUT_EN
    eng_hang = 1'b1; tmo_mode = 1'b1;
    send(4'h2, 16'h0005, 16'h0007, 1'b1);
    wait_idle(200);
    eng_hang = 1'b0; tmo_mode = 1'b0;
`else
    eng_hang = 1'b1;
    send(4'h2, 16'h0005, 16'h0007, 1'b0);
    repeat (150) @(negedge clk);
    check("hang_busy", 32'(busy), 32'h1);
    check("hang_no_rsp", 32'(rsp_valid), 32'h0);
    #2 n_rst = 1'b0;
    @(negedge clk); #2 n_rst = 1'b1;
    eng_hang = 1'b0;
`endif

    // reset mid-multiply
    send(4'h2, 16'h0101, 16'h0202, 1'b1);
    repeat (8) @(negedge clk);
    #2 n_rst = 1'b0;
    #1 check_reset_state("rst_mid");
    exp_q.delete();
    @(negedge clk); #2 n_rst = 1'b1;
    send(4'h2, 16'h0012, 16'h0034, 1'b1);
    wait_idle(100);

    // randomized traffic with random response back-pressure
    rdy_rand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 4) op = 4'h2;
      else if (r < 8) op = 4'h3;
      else begin
        op = 4'($urandom_range(0, 15));
        while (op == 4'h2 || op == 4'h3) op = 4'($urandom_range(0, 15));
      end
      send(op, pick_opnd(), pick_opnd(), 1'b1);
    end
    wait_idle(3000);
    rdy_rand = 1'b0;
    @(posedge clk); #2 rsp_ready = 1'b1;

    check("start_count", n_starts, legal_acc);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
